// File: rtl/bpm_update_scheduler.sv
// Single owner of the BPM setting: merges button/UART edits into a clamped shadow
// value and offers it to the metronome through a req/ack handshake.
module bpm_update_scheduler #(
  parameter int BPM_W         = 9,
  parameter int BPM_MIN       = 30,
  parameter int BPM_MAX       = 300,
  parameter int BPM_DEFAULT   = 120,
  parameter int HOLD_DELAY    = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_btn_plus_1,
  input  logic             i_btn_plus_5,
  input  logic             i_btn_minus_1,
  input  logic             i_btn_minus_5,
  input  logic             i_btn_plus_5_hold,
  input  logic             i_btn_minus_5_hold,
  input  logic             i_uart_msg,
  input  logic [31:0]      i_uart_bpm,
  input  logic             i_bpm_ack,
  output logic [BPM_W-1:0] o_bpm,
  output logic             o_bpm_req,
  output logic [BPM_W-1:0] o_shadow_bpm,
  output logic             o_hold_active,
  output logic             o_clamped
);

  localparam int AW = BPM_W + 2;
  localparam logic signed [AW-1:0] MIN_S   = AW'(BPM_MIN);
  localparam logic signed [AW-1:0] MAX_S   = AW'(BPM_MAX);
  localparam logic [31:0]          DLY_END = 32'(HOLD_DELAY - 1);
  localparam logic [31:0]          REP_END = 32'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {H_IDLE, H_WAIT, H_REPEAT} hold_state_t;
  typedef enum logic       {S_IDLE, S_REQ}            hs_state_t;

  hold_state_t      hold_state, hold_next;
  logic [31:0]      hold_cnt, cnt_next;
  logic             hold_dir, dir_next;     // 1: +5 repeat, 0: -5 repeat
  logic             repeat_tick;
  logic             one_hold;

  hs_state_t        hs_state, hs_next;
  logic [BPM_W-1:0] shadow, shadow_next;
  logic [BPM_W-1:0] bpm, bpm_next;
  logic             req, req_next;
  logic             clamp_next;

  logic signed [AW-1:0] pulse_delta, delta, sum;

  assign one_hold = i_btn_plus_5_hold ^ i_btn_minus_5_hold;

  // NOTE: every variable driven here gets a default first so no path can infer a latch.
  always_comb begin
    hold_next   = hold_state;
    cnt_next    = hold_cnt;
    dir_next    = hold_dir;
    repeat_tick = 1'b0;
    if (i_uart_msg) begin
      // A UART load restarts the hold timing from scratch.
      hold_next = one_hold ? H_WAIT : H_IDLE;
      cnt_next  = '0;
      dir_next  = i_btn_plus_5_hold;
    end else begin
      unique case (hold_state)
        H_IDLE: begin
          cnt_next = '0;
          if (one_hold) begin
            hold_next = H_WAIT;
            dir_next  = i_btn_plus_5_hold;
          end
        end
        H_WAIT, H_REPEAT: begin
          if (!one_hold || (i_btn_plus_5_hold != hold_dir)) begin
            hold_next = H_IDLE;
            cnt_next  = '0;
          end else if (hold_cnt == ((hold_state == H_WAIT) ? DLY_END : REP_END)) begin
            repeat_tick = 1'b1;
            hold_next   = H_REPEAT;
            cnt_next    = '0;
          end else begin
            cnt_next = hold_cnt + 32'd1;
          end
        end
        default: begin
          hold_next = H_IDLE;
          cnt_next  = '0;
        end
      endcase
    end
  end

  always_comb begin
    pulse_delta = '0;
    if (i_btn_plus_1)  pulse_delta = pulse_delta + AW'(1);
    if (i_btn_plus_5)  pulse_delta = pulse_delta + AW'(5);
    if (i_btn_minus_1) pulse_delta = pulse_delta - AW'(1);
    if (i_btn_minus_5) pulse_delta = pulse_delta - AW'(5);

    delta = repeat_tick ? (hold_dir ? AW'(5) : -AW'(5)) : pulse_delta;
    sum   = $signed({2'b00, shadow}) + delta;

    shadow_next = shadow;
    clamp_next  = 1'b0;
    if (i_uart_msg) begin
      if (i_uart_bpm < 32'(BPM_MIN)) begin
        shadow_next = BPM_W'(BPM_MIN);
        clamp_next  = 1'b1;
      end else if (i_uart_bpm > 32'(BPM_MAX)) begin
        shadow_next = BPM_W'(BPM_MAX);
        clamp_next  = 1'b1;
      end else begin
        shadow_next = i_uart_bpm[BPM_W-1:0];
      end
    end else if (repeat_tick || (pulse_delta != '0)) begin
      if (sum < MIN_S) begin
        shadow_next = BPM_W'(BPM_MIN);
        clamp_next  = 1'b1;
      end else if (sum > MAX_S) begin
        shadow_next = BPM_W'(BPM_MAX);
        clamp_next  = 1'b1;
      end else begin
        shadow_next = sum[BPM_W-1:0];
      end
    end
  end

  // Offered value is frozen while a request is outstanding; edits pile up in shadow.
  always_comb begin
    hs_next  = hs_state;
    bpm_next = bpm;
    req_next = req;
    unique case (hs_state)
      S_IDLE: if (shadow != bpm) begin
        bpm_next = shadow;
        req_next = 1'b1;
        hs_next  = S_REQ;
      end
      S_REQ: if (i_bpm_ack) begin
        req_next = 1'b0;
        hs_next  = S_IDLE;
      end
      default: begin
        req_next = 1'b0;
        hs_next  = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      hold_state <= H_IDLE;
      hold_cnt   <= '0;
      hold_dir   <= 1'b0;
      shadow     <= BPM_W'(BPM_DEFAULT);
      o_clamped  <= 1'b0;
      hs_state   <= S_IDLE;
      bpm        <= BPM_W'(BPM_DEFAULT);
      req        <= 1'b0;
    end else begin
      hold_state <= hold_next;
      hold_cnt   <= cnt_next;
      hold_dir   <= dir_next;
      shadow     <= shadow_next;
      o_clamped  <= clamp_next;
      hs_state   <= hs_next;
      bpm        <= bpm_next;
      req        <= req_next;
    end
  end

  assign o_bpm         = bpm;
  assign o_bpm_req     = req;
  assign o_shadow_bpm  = shadow;
  assign o_hold_active = (hold_state == H_REPEAT);

endmodule

// File: tb/tb_bpm_update_scheduler.sv
// Directed bench for bpm_update_scheduler with short hold timing (4 / 3 cycles).
module tb_bpm_update_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       p1, p5, m1, m5, p5_hold, m5_hold, uart_msg, ack;
  logic [31:0] uart_bpm;
  logic [8:0] o_bpm, o_shadow_bpm;
  logic       o_bpm_req, o_hold_active, o_clamped;

  logic [31:0] bpm_w, shadow_w, req_w, act_w, clamp_w;
  assign bpm_w    = 32'(o_bpm);
  assign shadow_w = 32'(o_shadow_bpm);
  assign req_w    = 32'(o_bpm_req);
  assign act_w    = 32'(o_hold_active);
  assign clamp_w  = 32'(o_clamped);

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bpm_update_scheduler #(
    .BPM_W(9), .BPM_MIN(30), .BPM_MAX(300), .BPM_DEFAULT(120),
    .HOLD_DELAY(4), .REPEAT_PERIOD(3)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .i_btn_plus_1(p1),
    .i_btn_plus_5(p5),
    .i_btn_minus_1(m1),
    .i_btn_minus_5(m5),
    .i_btn_plus_5_hold(p5_hold),
    .i_btn_minus_5_hold(m5_hold),
    .i_uart_msg(uart_msg),
    .i_uart_bpm(uart_bpm),
    .i_bpm_ack(ack),
    .o_bpm(o_bpm),
    .o_bpm_req(o_bpm_req),
    .o_shadow_bpm(o_shadow_bpm),
    .o_hold_active(o_hold_active),
    .o_clamped(o_clamped)
  );

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    {p1, p5, m1, m5, p5_hold, m5_hold, uart_msg, ack} = '0;
    uart_bpm = '0;
    rst_n    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_shadow", shadow_w, 120);
    check("rst_bpm", bpm_w, 120);
    check("rst_req", req_w, 0);
    check("rst_hold", act_w, 0);
    check("rst_clamp", clamp_w, 0);

    // +5 pulse, ack three cycles after the request
    p5 = 1; tick(); p5 = 0;
    check("p5_shadow", shadow_w, 125);
    check("p5_req_n1", req_w, 0);
    check("p5_bpm_n1", bpm_w, 120);
    tick();
    check("p5_bpm_n2", bpm_w, 125);
    check("p5_req_n2", req_w, 1);
    tick(); tick();
    check("p5_req_hold", req_w, 1);
    ack = 1; tick(); ack = 0;
    check("p5_req_drop", req_w, 0);
    tick();
    check("p5_req_stay", req_w, 0);

    // UART over-range with a simultaneous +1 that must be ignored
    uart_msg = 1; uart_bpm = 1000; p1 = 1; tick(); uart_msg = 0; p1 = 0;
    check("u1000_shadow", shadow_w, 300);
    check("u1000_clamp", clamp_w, 1);
    tick();
    check("u1000_bpm", bpm_w, 300);
    check("u1000_req", req_w, 1);
    check("u1000_clamp_end", clamp_w, 0);
    // +1 at MAX: value unchanged but still flagged
    p1 = 1; tick(); p1 = 0;
    check("max_p1_shadow", shadow_w, 300);
    check("max_p1_clamp", clamp_w, 1);
    ack = 1; tick(); ack = 0;
    check("u1000_ack", req_w, 0);
    check("max_p1_clamp_end", clamp_w, 0);
    tick();
    check("no_req_equal", req_w, 0);

    // UART under-range
    uart_msg = 1; uart_bpm = 5; tick(); uart_msg = 0;
    check("u5_shadow", shadow_w, 30);
    check("u5_clamp", clamp_w, 1);
    tick();
    check("u5_bpm", bpm_w, 30);
    check("u5_req", req_w, 1);
    ack = 1; tick(); ack = 0;
    check("u5_ack", req_w, 0);

    // Auto-repeat: hold high for 14 cycles from 120
    do_reset();
    tick();
    p5_hold = 1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      check($sformatf("hold_shadow_%0d", k), shadow_w,
            (k < 5) ? 120 : (k < 8) ? 125 : (k < 11) ? 130 : (k < 14) ? 135 : 140);
      check($sformatf("hold_active_%0d", k), act_w, (k >= 5) ? 1 : 0);
    end
    p5_hold = 0;
    check("hold_bpm_frozen", bpm_w, 125);
    tick();
    check("hold_release", act_w, 0);
    check("hold_final", shadow_w, 140);
    ack = 1; tick(); ack = 0;
    check("hold_ack", req_w, 0);
    tick();
    check("hold_rereq_bpm", bpm_w, 140);
    check("hold_rereq", req_w, 1);
    ack = 1; tick(); ack = 0;

    // Both hold inputs together: no stepping
    p5_hold = 1; m5_hold = 1;
    for (int k = 0; k < 8; k++) tick();
    check("both_active", act_w, 0);
    check("both_shadow", shadow_w, 140);
    p5_hold = 0; m5_hold = 0;
    tick();

    // Coalescing while the request is outstanding
    do_reset();
    p5 = 1; tick(); p5 = 0;
    tick();
    check("coal_req", req_w, 1);
    p1 = 1; tick(); p1 = 0;
    p5 = 1; tick(); p5 = 0;
    m1 = 1; tick(); m1 = 0;
    check("coal_bpm_frozen", bpm_w, 125);
    check("coal_shadow", shadow_w, 130);
    ack = 1; tick(); ack = 0;
    check("coal_drop", req_w, 0);
    check("coal_drop_bpm", bpm_w, 125);
    tick();
    check("coal_rereq", req_w, 1);
    check("coal_rereq_bpm", bpm_w, 130);
    ack = 1; tick(); ack = 0;

    // Simultaneous +5 and -1 sum to +4
    p5 = 1; m1 = 1; tick(); p5 = 0; m1 = 0;
    check("sum_shadow", shadow_w, 134);
    tick();
    check("sum_bpm", bpm_w, 134);
    // +1 then -1 during the request: no new request afterwards
    p1 = 1; tick(); p1 = 0;
    m1 = 1; tick(); m1 = 0;
    ack = 1; tick(); ack = 0;
    tick();
    check("cancel_req", req_w, 0);
    check("cancel_bpm", bpm_w, 134);

    // Reset in the middle of a handshake, then a stray ack
    p1 = 1; tick(); p1 = 0;
    tick();
    check("mid_req", req_w, 1);
    rst_n = 0; tick(); rst_n = 1;
    check("mid_rst_bpm", bpm_w, 120);
    check("mid_rst_req", req_w, 0);
    check("mid_rst_shadow", shadow_w, 120);
    ack = 1; tick(); ack = 0;
    check("stray_ack_req", req_w, 0);
    check("stray_ack_bpm", bpm_w, 120);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bpm_update_scheduler.md
Name: bpm_update_scheduler

Overview:
- Sole owner of the BPM setting. Merges debounced button events (±1, ±5, ±5 auto-repeat hold) and UART BPM messages into one clamped shadow BPM.
- Hands the shadow value to the metronome through a req/ack handshake; the metronome acks at a beat boundary.
- Edits made while a request is outstanding are coalesced into the shadow and re-requested after the ack.
- Sits in the pll_clk domain between btn_debouncer / uart_receive_bpm (UART side already synchronised to i_clk) and metronome.

Parameters:
- BPM_W, 9, width of BPM values
- BPM_MIN, 30, lowest legal BPM
- BPM_MAX, 300, highest legal BPM
- BPM_DEFAULT, 120, BPM after reset
- HOLD_DELAY, 25000000, cycles a hold input must stay high before the first repeat step
- REPEAT_PERIOD, 5000000, cycles between repeat steps once repeating

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_reset_n  in  1  synchronous active-low reset
- i_btn_plus_1  in  1  one-cycle pulse, +1
- i_btn_plus_5  in  1  one-cycle pulse, +5
- i_btn_minus_1  in  1  one-cycle pulse, -1
- i_btn_minus_5  in  1  one-cycle pulse, -5
- i_btn_plus_5_hold  in  1  level, +5 auto-repeat request
- i_btn_minus_5_hold  in  1  level, -5 auto-repeat request
- i_uart_msg  in  1  one-cycle pulse, i_uart_bpm valid
- i_uart_bpm  in  32  requested BPM, unsigned
- i_bpm_ack  in  1  metronome accepted o_bpm
- o_bpm  out  BPM_W  BPM offered to metronome; stable while o_bpm_req=1
- o_bpm_req  out  1  load request
- o_shadow_bpm  out  BPM_W  latest edited BPM (drives display preview)
- o_hold_active  out  1  auto-repeat currently stepping
- o_clamped  out  1  one-cycle pulse: last edit was clamped to MIN/MAX

Behaviour:
- Reset values (i_reset_n=0 at an edge): shadow=o_bpm=BPM_DEFAULT, o_bpm_req=0, o_hold_active=0, o_clamped=0, hold FSM=H_IDLE, hold counter=0.
  - Reset mid-handshake drops o_bpm_req immediately; any pending edit is discarded.
- Edit arbitration, evaluated each cycle, highest priority first:
  - 1. i_uart_msg: shadow = clamp(i_uart_bpm). All button and repeat activity that cycle is ignored; the hold FSM restarts at H_WAIT if a hold input is still high.
  - 2. Repeat tick: shadow = clamp(shadow ± 5). Same-cycle single-step pulses are ignored.
  - 3. Pulses: delta = +1·p1 +5·p5 −1·m1 −5·m5, summed if simultaneous (e.g. p5+m1 → +4). delta=0 → no edit.
- Arithmetic:
  - Compute in signed BPM_W+2 bits, then clamp to [BPM_MIN, BPM_MAX]. The UART value is compared as a full 32-bit value.
  - o_clamped pulses the cycle after an edit whose unclamped result was outside the range, including an edit that leaves the value unchanged (e.g. +1 at BPM_MAX).
- Hold FSM (single 32-bit counter):
  - H_IDLE: exactly one hold input high → H_WAIT, counter=0. Both high or neither high → stay.
  - H_WAIT: counter increments. At HOLD_DELAY−1 → repeat tick, H_REPEAT, counter=0. Hold released or both high → H_IDLE.
  - H_REPEAT: o_hold_active=1. Counter reaching REPEAT_PERIOD−1 → repeat tick, counter=0. Release or both high → H_IDLE.
  - A direction change with no idle cycle in between passes through H_IDLE for one cycle.
- Handshake FSM:
  - S_IDLE: if shadow != o_bpm, then o_bpm<=shadow, o_bpm_req<=1, go to S_REQ.
  - S_REQ: o_bpm frozen. i_bpm_ack=1 → o_bpm_req<=0, S_IDLE. Edits continue to update the shadow only.
  - i_bpm_ack while o_bpm_req=0 is ignored.
- Latency: event at cycle N → shadow updated at edge N+1 → o_bpm/o_bpm_req at edge N+2, when in S_IDLE.
  - Ack at cycle M with shadow != o_bpm → o_bpm_req low during M+1, re-asserted with the new value at M+2. Minimum one idle cycle between requests.
- No request is issued when the final shadow equals o_bpm (e.g. +1 then −1 while in S_REQ).

Test Plan:
- Reset, then i_btn_plus_5 pulse, metronome acks 3 cycles after req → o_shadow_bpm=125 at N+1; o_bpm=125, o_bpm_req=1 at N+2; o_bpm_req=0 the cycle after ack.
- i_uart_msg with i_uart_bpm=1000, then i_uart_bpm=5 → o_bpm 300 then 30; o_clamped pulses twice. Simultaneous i_btn_plus_1 with the UART pulse is ignored.
- HOLD_DELAY=4, REPEAT_PERIOD=3, i_btn_plus_5_hold high 13 cycles from 120 → ticks at cycles 4, 7, 10, 13 → shadow 140; o_hold_active high from cycle 5 to release.
- Both hold inputs high together → no ticks, o_hold_active=0, shadow unchanged.
- o_bpm_req held without ack; pulses +1, +5, −1 → o_bpm frozen at 125, shadow 130. Ack → req drops, re-asserts with o_bpm=130 two cycles later.
- i_reset_n low for one cycle during S_REQ → o_bpm=120 and o_bpm_req=0 next cycle; a later ack is ignored.
